// File: rtl/midway8080_mem_pkg.sv
// Shared types and helpers for the Midway/Taito 8080 memory subsystem.
package midway8080_mem_pkg;

  localparam int unsigned MAX_BANKS = 8;
  localparam int unsigned MAP_W     = 5 * MAX_BANKS;

  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} mem_state_e;

  typedef logic [4:0] page_t;

  // Returns {hit, index}; the lowest-index bank wins when pages repeat.
  function automatic logic [3:0] bank_decode(input page_t page,
                                             input logic [MAP_W-1:0] map,
                                             input int unsigned num_banks);
    logic       hit;
    logic [2:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < MAX_BANKS; i++) begin
      if (!hit && (i < num_banks) && (map[5*i +: 5] == page)) begin
        hit = 1'b1;
        idx = 3'(i);
      end
    end
    return {hit, idx};
  endfunction

  // Fixed factory image used when ROMs are read-only; a board build swaps in
  // its own dumped contents here.
  function automatic logic [7:0] rom_image_byte(input logic [2:0] bank,
                                                input logic [15:0] offset);
    return offset[7:0] ^ offset[15:8] ^ {bank, 5'b0_0000} ^ 8'h11;
  endfunction

endpackage

// File: rtl/midway8080_rom_bank.sv
// One 2^BANK_AW x 8 program-ROM bank with a registered read port.
// ROM_DOWNLOAD_EN: the bank becomes writable through the download port.
module midway8080_rom_bank
  import midway8080_mem_pkg::*;
#(
  parameter int unsigned BANK_AW  = 11,
  parameter int unsigned BANK_IDX = 0
) (
  input  logic               clk,
  input  logic               rd_en,
  input  logic [BANK_AW-1:0] rd_addr,
  output logic [7:0]         rd_data,
  input  logic               wr_en,
  input  logic [BANK_AW-1:0] wr_addr,
  input  logic [7:0]         wr_data
);

`ifdef ROM_DOWNLOAD_EN
  logic [7:0] mem [2**BANK_AW];

  // Download writes land directly in the bank storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; the output holds until the next accepted read.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};

  // Registered read from the fixed image; holds until the next accepted read.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= rom_image_byte(3'(BANK_IDX), 16'(rd_addr));
  end
`endif

endmodule

// File: rtl/midway8080_mem_ctrl.sv
// CPU memory subsystem: paged program-ROM banks plus work/video RAM, with a
// request/valid read handshake, 1- or 2-cycle read latency and a post-reset
// RAM clear sequencer.
// ROM_DOWNLOAD_EN: ROM banks are loaded through the Dl_* port via a LOAD state.
module midway8080_mem_ctrl
  import midway8080_mem_pkg::*;
#(
  parameter int unsigned             NUM_BANKS = 5,
  parameter int unsigned             BANK_AW   = 11,
  parameter int unsigned             RAM_AW    = 13,
  parameter logic [5*NUM_BANKS-1:0]  PAGE_MAP  = {5'h08, 5'h03, 5'h02, 5'h01, 5'h00},
  parameter int unsigned             READ_LAT  = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Cpu_Req,
  input  logic        RW_n,
  input  logic [15:0] Addr,
  input  logic [15:0] Ram_Addr,
  input  logic [7:0]  Ram_in,
  output logic [7:0]  Ram_out,
  output logic [7:0]  Rom_out,
  output logic        Rom_hit,
  output logic        Data_Valid,
  output logic        Ready,
  input  logic        Dl_Wr,
  input  logic [15:0] Dl_Addr,
  input  logic [7:0]  Dl_Data,
  input  logic        Dl_Active
);

  localparam logic [MAP_W-1:0] MAP_EXT = MAP_W'(PAGE_MAP);

  mem_state_e        state, state_nx;
  logic [RAM_AW-1:0] clr_cnt;
  logic              clr_last;
  logic              accept, rd_acc, wr_acc;
  logic [3:0]        dec;
  logic [RAM_AW-1:0] ram_a;
  logic [7:0]        ram [2**RAM_AW];
  logic [7:0]        ram_q;
  logic              s1_valid, s1_hit;
  logic [2:0]        s1_idx;
  logic [7:0]        rom_s1;
  logic [7:0]        bank_data [MAX_BANKS];

  assign clr_last = &clr_cnt;
  assign Ready    = (state == IDLE);
  assign accept   = Cpu_Req && Ready && !Reset;
  assign rd_acc   = accept && RW_n;
  assign wr_acc   = accept && !RW_n;
  assign dec      = bank_decode(Addr[15:11], MAP_EXT, NUM_BANKS);
  assign ram_a    = Ram_Addr[RAM_AW-1:0];

`ifdef ROM_DOWNLOAD_EN
  logic [15:0] dl_bank;
  assign dl_bank = Dl_Addr >> BANK_AW;
  logic unused_bits;
  assign unused_bits = ^{Ram_Addr[15:RAM_AW]};
`else
  logic unused_bits;
  assign unused_bits = ^{Ram_Addr[15:RAM_AW], Dl_Wr, Dl_Addr, Dl_Active};
`endif

  // State register and clear address counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= (state == CLEAR) ? clr_cnt + RAM_AW'(1) : '0;
    end
  end

  // Next-state logic; the terminal clear address ends the sweep instead of wrapping.
  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (clr_last) state_nx = IDLE;
      IDLE: begin
`ifdef ROM_DOWNLOAD_EN
        if (Dl_Active) state_nx = LOAD;
`endif
      end
      LOAD: begin
`ifdef ROM_DOWNLOAD_EN
        if (!Dl_Active) state_nx = CLEAR;
`else
        state_nx = CLEAR;
`endif
      end
      default: state_nx = CLEAR;
    endcase
  end

  // RAM write port shared by the clear sweep and CPU writes.
  always_ff @(posedge Clock) begin
    if (state == CLEAR) ram[clr_cnt] <= '0;
    else if (wr_acc)    ram[ram_a]   <= Ram_in;
  end

  // RAM read register, updated only on accepted reads.
  always_ff @(posedge Clock) begin
    if (Reset)       ram_q <= '0;
    else if (rd_acc) ram_q <= ram[ram_a];
  end

  // First read stage: valid flag and page decode captured with the request.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_hit <= dec[3];
        s1_idx <= dec[2:0];
      end
    end
  end

  assign rom_s1 = s1_hit ? bank_data[s1_idx] : 8'h00;

  for (genvar i = 0; i < MAX_BANKS; i++) begin : g_banks
    if (i < NUM_BANKS) begin : g_bank
      logic wr_en_i;
`ifdef ROM_DOWNLOAD_EN
      assign wr_en_i = (state == LOAD) && Dl_Wr && (dl_bank == 16'(i));
`else
      assign wr_en_i = 1'b0;
`endif
      midway8080_rom_bank #(
        .BANK_AW (BANK_AW),
        .BANK_IDX(i)
      ) u_bank (
        .clk    (Clock),
        .rd_en  (rd_acc),
        .rd_addr(Addr[BANK_AW-1:0]),
        .rd_data(bank_data[i]),
        .wr_en  (wr_en_i),
        .wr_addr(Dl_Addr[BANK_AW-1:0]),
        .wr_data(Dl_Data)
      );
    end else begin : g_nobank
      assign bank_data[i] = 8'h00;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    // Second read stage; outputs hold between valid pulses.
    always_ff @(posedge Clock) begin
      if (Reset) begin
        Data_Valid <= 1'b0;
        Rom_hit    <= 1'b0;
        Rom_out    <= '0;
        Ram_out    <= '0;
      end else begin
        Data_Valid <= s1_valid;
        if (s1_valid) begin
          Rom_hit <= s1_hit;
          Rom_out <= rom_s1;
          Ram_out <= ram_q;
        end
      end
    end
  end else begin : g_lat1
    // Single-cycle latency: the first stage registers are the outputs.
    assign Data_Valid = s1_valid;
    assign Rom_hit    = s1_hit;
    assign Rom_out    = rom_s1;
    assign Ram_out    = ram_q;
  end

endmodule
